sin_rom_reader: RTL and testbench
=================================

Name: sin_rom_reader

Overview:
Read-side master for the single-port registered-address sine ROM: a phase-accumulator sequencer that drives ROM ce/addr and collects the 1-cycle-latency data into a 2-entry output buffer. Emits samples on a valid/ready stream. Sits between the waveform ROM and downstream DSP/DAC logic. Supports bursts of N samples or continuous run, with backpressure.

Parameters:
DW, 16, ROM data width / sample width
AW, 8, ROM address width (table depth 2**AW)
PW, 24, phase accumulator width; PW >= AW
LW, 16, burst length counter width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; begin burst (ignored unless IDLE)
stop  input  1  pulse; abort/finish run (ignored in IDLE)
fcw  input  PW  frequency control word, latched on accepted start
phase_init  input  PW  initial phase, latched on accepted start
burst_len  input  LW  samples per burst, latched on start; 0 = continuous
rom_ce  output  1  ROM read enable (one read per high cycle)
rom_addr  output  AW  ROM address = phase_acc[PW-1:PW-AW]
rom_data  input  DW  ROM read data, valid the cycle after rom_ce
m_valid  output  1  output sample valid
m_ready  input  1  downstream accept
m_data  output  DW  output sample
busy  output  1  state != IDLE
done  output  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset (rst_n low, async): state IDLE, phase_acc 0, remain 0, inflight 0, buffer empty; rom_ce 0, rom_addr 0, m_valid 0, m_data 0, busy 0, done 0.
- States: IDLE, RUN, DRAIN.
- IDLE: on start -> RUN; latch fcw, burst_len into remain, phase_acc <= phase_init. stop ignored; start+stop same cycle in IDLE = start.
- RUN: issue = (remain != 0 or continuous) and (occ + inflight - pop) < 2, where pop = m_valid & m_ready, occ = buffer occupancy (0..2), inflight = read issued previous cycle. rom_ce = issue (combinational). On issue: phase_acc <= phase_acc + fcw (mod 2**PW, wrap silently); remain decrements (burst mode only); inflight <= 1, else inflight <= 0.
- RUN -> DRAIN when stop sampled, or when the issue that takes remain to 0 occurs. stop in same cycle as an issue: that issue still completes and its sample is delivered.
- DRAIN: no issues; rom_ce 0. When inflight = 0 and occ = 0 -> IDLE with done = 1 for that one cycle. start/stop ignored in RUN and DRAIN.
- Capture: cycle after issue, rom_data is written into the buffer. Overflow cannot occur by construction; overflow is an assertion failure.
- Buffer: 2-entry FIFO; m_valid = occ != 0; m_data = head. m_data and m_valid are stable while m_valid & !m_ready. Push and pop in the same cycle are allowed.
- Latency: start sampled at edge T0; rom_ce high during cycle T0..T1; m_valid high from T2.
- Throughput: with m_ready held 1, one sample per cycle sustained.
- Sample k value = ROM[((phase_init + k*fcw) mod 2**PW) >> (PW-AW)].
- rom_addr when not issuing: holds the current phase_acc slice (don't-care for ROM since ce = 0).
- Reset mid-operation: immediate return to reset values; buffered samples are lost; no done pulse.

Test Plan:
All tests use an identity ROM model (mem[i] = i) with 1-cycle registered address and PW = 24, AW = 8.
1. Basic burst: fcw=0x010000, phase_init=0, burst_len=4, m_ready=1 -> m_data 0,1,2,3 on consecutive cycles; first m_valid 2 cycles after start edge; exactly 4 rom_ce pulses; done pulse one cycle after the last beat; busy falls with done.
2. Wrap-around: phase_init=0xFE0000, fcw=0x010000, len=4 -> 0xFE,0xFF,0x00,0x01.
3. Fractional step: fcw=0x008000, phase_init=0, len=6 -> 0,0,1,1,2,2.
4. Backpressure: len=8; m_ready toggles 1,0,0,1,... and is held 0 for 5 cycles mid-burst -> no sample lost or duplicated; values 0..7 in order; m_data stable while stalled; rom_ce never raises occ+inflight above 2.
5. Continuous + stop: burst_len=0, fcw=0x010000; pulse stop after 10 issued reads -> all 10 issued samples (0..9) delivered, plus the sample of an issue coinciding with stop; then done; start during DRAIN ignored.
6. Reset mid-run: deassert rst_n while occ=2 -> outputs 0 asynchronously, no done; a new start after reset produces a correct fresh burst.

Source files
------------

// File: rtl/sin_rom_reader_if.sv
// sin_rom_reader_if: valid/ready sample stream between the ROM reader and its consumer.
interface sin_rom_reader_if #(parameter int DW = 16);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    modport master(output valid, data, input ready);
    modport slave(input valid, data, output ready);
endinterface

// File: rtl/sin_rom_reader.sv
// sin_rom_reader: phase-accumulator read master for a 1-cycle-latency sine ROM,
// buffering samples in a 2-entry FIFO and streaming them out with backpressure.
module sin_rom_reader #(
    parameter int DW = 16,
    parameter int AW = 8,
    parameter int PW = 24,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [PW-1:0] fcw,
    input  logic [PW-1:0] phase_init,
    input  logic [LW-1:0] burst_len,
    output logic          rom_ce,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    sin_rom_reader_if.master m,
    output logic          busy,
    output logic          done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] phase_acc;
    logic [PW-1:0] fcw_r;
    logic [LW-1:0] remain;
    logic          cont;
    logic          inflight;
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    occ;
    logic [DW-1:0] mem [2];
    logic          pop;
    logic          issue;

    assign pop     = m.valid & m.ready;
    assign m.valid = occ != 2'd0;
    assign m.data  = mem[rd_ptr];
    // a slot must be free once this cycle's pop and the pending capture are accounted for
    assign issue   = state == RUN && (cont || remain != '0)
                     && ({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
    assign rom_ce   = issue;
    assign rom_addr = phase_acc[PW-1 -: AW];
    assign busy     = state != IDLE;
    assign done     = state == DRAIN && !inflight && occ == 2'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase_acc <= '0;
            fcw_r     <= '0;
            remain    <= '0;
            cont      <= 1'b0;
            inflight  <= 1'b0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            occ       <= 2'd0;
            mem[0]    <= '0;
            mem[1]    <= '0;
        end else begin
            inflight <= issue;
            if (inflight) begin
                mem[wr_ptr] <= rom_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
            if (state == IDLE && start) begin
                state     <= RUN;
                fcw_r     <= fcw;
                remain    <= burst_len;
                cont      <= burst_len == '0;
                phase_acc <= phase_init;
            end
            if (issue) begin
                phase_acc <= phase_acc + fcw_r;
                if (!cont) remain <= remain - 1'b1;
            end
            if (state == RUN && (stop || (issue && !cont && remain == LW'(1)))) state <= DRAIN;
            if (done) state <= IDLE;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(inflight && occ == 2'd2 && !pop));
endmodule

// File: tb/tb_sin_rom_reader.sv
// tb_sin_rom_reader: directed and random bursts against an identity ROM, with a
// sample-sequence model checked every cycle plus literal expectations.
module tb_sin_rom_reader;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int PW = 24;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [PW-1:0] fcw = '0;
    logic [PW-1:0] phase_init = '0;
    logic [LW-1:0] burst_len = '0;
    logic          rom_ce;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = '0;
    logic          busy;
    logic          done;
    logic          m_ready = 1'b1;
    logic          m_valid;
    logic [DW-1:0] m_data;

    int total = 0;
    int bad = 0;

    sin_rom_reader_if #(.DW(DW)) s();
    assign s.ready = m_ready;
    assign m_valid = s.valid;
    assign m_data  = s.data;

    sin_rom_reader #(.DW(DW), .AW(AW), .PW(PW), .LW(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .fcw(fcw),
        .phase_init(phase_init), .burst_len(burst_len), .rom_ce(rom_ce),
        .rom_addr(rom_addr), .rom_data(rom_data), .m(s), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // identity ROM with registered address
    always @(posedge clk) if (rom_ce) rom_data <= DW'(rom_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] ea(input logic [PW-1:0] p, input logic [PW-1:0] f, input int kk);
        logic [63:0] ph;
        ph = 64'(p) + 64'(f) * 64'(kk);
        return ph[PW-1 -: AW];
    endfunction

    // behavioural model: sample k of a run is ROM[(phase_init + k*fcw) >> (PW-AW)]
    logic          mbusy = 1'b0;
    logic          mstop = 1'b0;
    logic          mcont = 1'b0;
    logic [PW-1:0] mf = '0;
    logic [PW-1:0] mp = '0;
    int            mlen = 0;
    int            k = 0;
    int            q[$];
    logic          pv = 1'b0;
    logic [DW-1:0] pd = '0;
    logic          idle_snap;

    always @(negedge clk) begin
        if (!rst_n) begin
            mbusy = 1'b0;
            mstop = 1'b0;
            k = 0;
            q.delete();
            pv = 1'b0;
        end else begin
            idle_snap = !mbusy;
            chk("busy", busy, mbusy);
            if (rom_ce) begin
                chk("issue_allowed", mbusy && !mstop && (mcont || k < mlen), 1);
                chk("rom_addr", rom_addr, ea(mp, mf, k));
                q.push_back(int'(ea(mp, mf, k)));
                k++;
            end
            if (pv) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, pd);
            end
            if (m_valid) begin
                chk("valid_has_sample", q.size() != 0, 1);
                if (q.size() != 0) begin
                    chk("m_data", m_data, q[0]);
                    if (m_ready) void'(q.pop_front());
                end
            end
            chk("outstanding_le_2", q.size() <= 2, 1);
            if (done) begin
                chk("done_expected", mbusy && q.size() == 0 && (mcont || mstop || k == mlen), 1);
                mbusy = 1'b0;
            end
            pv = m_valid && !m_ready;
            pd = m_data;
            if (start && idle_snap) begin
                mbusy = 1'b1;
                mstop = 1'b0;
                mf = fcw;
                mp = phase_init;
                mlen = int'(burst_len);
                mcont = burst_len == '0;
                k = 0;
                q.delete();
            end else if (stop && mbusy) begin
                mstop = 1'b1;
            end
        end
    end

    function automatic logic rdy(input int mode, input int i);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (i >= 6 && i < 11) ? 1'b0 : (i % 3 == 0);
        return $urandom_range(0, 3) != 0;
    endfunction

    int got[$];
    int exp_q[$];
    int nce;

    task automatic run(input logic [PW-1:0] f, input logic [PW-1:0] p, input logic [LW-1:0] l,
                       input int mode, input int stop_at);
        bit ok;
        bit sent;
        ok = 0;
        sent = 0;
        nce = 0;
        got.delete();
        @(posedge clk); #1;
        fcw = f;
        phase_init = p;
        burst_len = l;
        start = 1'b1;
        m_ready = rdy(mode, 0);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (m_valid && m_ready) got.push_back(int'(m_data));
            if (rom_ce) nce++;
            if (done) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
            m_ready = rdy(mode, i + 1);
            // a start pulse lands right after stop, while the block is draining
            start = stop;
            stop = stop_at != 0 && nce >= stop_at && !sent;
            if (stop) sent = 1;
        end
        start = 1'b0;
        stop = 1'b0;
        m_ready = 1'b1;
        chk("done_seen", ok, 1);
    endtask

    task automatic check_got(input string name);
        chk({name, "_count"}, got.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < got.size(); j++) chk({name, "_data"}, got[j], exp_q[j]);
    endtask

    task automatic check_reset_outs(input string name);
        chk({name, "_rom_ce"}, rom_ce, 0);
        chk({name, "_rom_addr"}, rom_addr, 0);
        chk({name, "_m_valid"}, m_valid, 0);
        chk({name, "_m_data"}, m_data, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
    endtask

    logic [7:0] ce_v, v_v, d_v, b_v;

    initial begin
        repeat (3) @(posedge clk);
        #1 check_reset_outs("reset");
        rst_n = 1'b1;

        // basic burst with cycle-exact timing
        @(posedge clk); #1;
        fcw = 24'h010000;
        phase_init = '0;
        burst_len = 16'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ce_v[i] = rom_ce;
            v_v[i] = m_valid;
            d_v[i] = done;
            b_v[i] = busy;
            if (m_valid) got.push_back(int'(m_data));
        end
        chk("t1_ce", ce_v, 8'h0F);
        chk("t1_valid", v_v, 8'h3C);
        chk("t1_done", d_v, 8'h40);
        chk("t1_busy", b_v, 8'h7F);
        exp_q = '{0, 1, 2, 3};
        check_got("t1");

        run(24'hFE0000 - 24'hFE0000 + 24'h010000, 24'hFE0000, 16'd4, 0, 0);
        exp_q = '{254, 255, 0, 1};
        check_got("t2_wrap");

        run(24'h008000, 24'h000000, 16'd6, 0, 0);
        exp_q = '{0, 0, 1, 1, 2, 2};
        check_got("t3_frac");

        run(24'h010000, 24'h000000, 16'd8, 1, 0);
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
        check_got("t4_bp");

        run(24'h010000, 24'h000000, 16'd0, 0, 10);
        exp_q.delete();
        for (int j = 0; j < 11; j++) exp_q.push_back(j);
        check_got("t5_cont");
        repeat (3) @(negedge clk);
        chk("t5_start_in_drain_busy", busy, 0);
        chk("t5_start_in_drain_ce", rom_ce, 0);

        // reset while the buffer is full and stalled
        @(posedge clk); #1;
        fcw = 24'h010000;
        phase_init = '0;
        burst_len = 16'd8;
        start = 1'b1;
        m_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_valid_before", m_valid, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outs("t6_async");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        m_ready = 1'b1;
        run(24'h010000, 24'h050000, 16'd3, 0, 0);
        exp_q = '{5, 6, 7};
        check_got("t6_fresh");

        for (int r = 0; r < 8; r++) begin
            logic [LW-1:0] l;
            l = LW'($urandom_range(1, 12));
            run(PW'($urandom), PW'($urandom), l, 2, 0);
            chk("rnd_burst_count", got.size(), int'(l));
        end
        for (int r = 0; r < 3; r++) begin
            run(PW'($urandom), PW'($urandom), 16'd0, 2, int'($urandom_range(1, 6)));
            chk("rnd_cont_all_delivered", got.size(), nce);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
